// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared register offsets, STATUS bit positions and fill-engine state for MCPU peripherals
package mcpu_pkg;
   localparam logic [1:0] REG_ADDR     = 2'd0;
   localparam logic [1:0] REG_DATA     = 2'd1;
   localparam logic [1:0] REG_FILL_VAL = 2'd2;
   localparam logic [1:0] REG_FILL_CNT = 2'd3;
   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_DISP  = 4;
   localparam int ST_LEVEL = 8;
   typedef enum logic {IDLE, FILL} fill_state_t;
endpackage

// File: rtl/mcpu_sync_fifo.sv
// mcpu_sync_fifo: single-clock FIFO with occupancy level
// Ports: clk/reset (sync, active-high); push/din enqueue; pop dequeues dout (head, show-ahead);
//        full/empty/level report occupancy. Push while full or pop while empty is ignored.
module mcpu_sync_fifo #(
   parameter int WIDTH = 21,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int PW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] wp, rp;
   logic do_push, do_pop;
   assign do_push = push & ~full;
   assign do_pop = pop & ~empty;
   assign full = level == (PW+1)'(DEPTH);
   assign empty = level == '0;
   assign dout = mem[rp];
   always_ff @(posedge clk)
      if (do_push) mem[wp] <= din;
   always_ff @(posedge clk)
      if (reset) begin
         wp <= '0;
         rp <= '0;
         level <= '0;
      end else begin
         wp <= wp + PW'(do_push);
         rp <= rp + PW'(do_pop);
         level <= level + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
endmodule

// File: rtl/mcpu_vram_bridge.sv
// mcpu_vram_bridge: CPU register window that queues VRAM writes and drains them during blanking
// Ports: bus_addr/bus_wdata/bus_we/bus_re - CPU data bus; bus_rdata/bus_rdata_oe - read return;
//        display_on - active video (no drain while high); vram_addr/vram_wdata/vram_we - GPU write port.
module mcpu_vram_bridge
   import mcpu_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDR = 16'hFF00,
   parameter int VRAM_AW = 13,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] bus_addr,
   input  logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic                  bus_we,
   input  logic                  bus_re,
   output logic [DATA_WIDTH-1:0] bus_rdata,
   output logic                  bus_rdata_oe,
   input  logic                  display_on,
   output logic [VRAM_AW-1:0]    vram_addr,
   output logic [7:0]            vram_wdata,
   output logic                  vram_we
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   fill_state_t state, state_nx;
   logic [VRAM_AW-1:0] addr;
   logic [7:0] fill_val;
   logic [DATA_WIDTH-1:0] cnt, off, status;
   logic [LW-1:0] level;
   logic [VRAM_AW+7:0] din, dout;
   logic ovf, hit, wr, busy, fifo_full, fifo_empty;
   logic fill_push, cpu_push, pop, drop, rd_status;
   logic wr_addr, wr_data, wr_fval, wr_fcnt;
   assign off = bus_addr - BASE_ADDR;
   assign hit = off < DATA_WIDTH'(4);
   assign wr = bus_we & hit;
   assign wr_addr = wr & (off[1:0] == REG_ADDR);
   assign wr_data = wr & (off[1:0] == REG_DATA);
   assign wr_fval = wr & (off[1:0] == REG_FILL_VAL);
   assign wr_fcnt = wr & (off[1:0] == REG_FILL_CNT);
   assign busy = state == FILL;
   assign bus_rdata_oe = bus_re & hit;
   assign rd_status = bus_rdata_oe & (off[1:0] == REG_DATA);
   assign status = DATA_WIDTH'({8'(level), 3'b000, display_on, ovf, busy, fifo_full, fifo_empty});
   assign bus_rdata = !hit ? '0 :
                      off[1:0] == REG_ADDR     ? DATA_WIDTH'(addr) :
                      off[1:0] == REG_DATA     ? status :
                      off[1:0] == REG_FILL_VAL ? DATA_WIDTH'(fill_val) : cnt;
   // The fill engine owns the FIFO input while busy, so a CPU push can never coincide with it.
   assign fill_push = busy & ~fifo_full;
   assign cpu_push = wr_data & ~busy & ~fifo_full;
   assign drop = (wr_data & (busy | fifo_full)) | (busy & (wr_addr | wr_fcnt));
   assign din = {addr, busy ? fill_val : bus_wdata[7:0]};
   assign pop = ~fifo_empty & ~display_on;
   mcpu_sync_fifo #(.WIDTH(VRAM_AW + 8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(fill_push | cpu_push), .pop(pop), .din(din),
      .dout(dout), .full(fifo_full), .empty(fifo_empty), .level(level)
   );
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      if (state == IDLE && wr_fcnt && bus_wdata != '0) state_nx = FILL;
      if (state == FILL && fill_push && cnt == DATA_WIDTH'(1)) state_nx = IDLE;
   end
   always_ff @(posedge clk)
      if (reset) begin
         addr <= '0;
         fill_val <= '0;
         cnt <= '0;
         ovf <= 1'b0;
         vram_we <= 1'b0;
         vram_addr <= '0;
         vram_wdata <= '0;
      end else begin
         // A new overflow on the same edge as a STATUS read must survive the clear.
         if (drop) ovf <= 1'b1;
         else if (rd_status) ovf <= 1'b0;
         if (wr_fval) fill_val <= bus_wdata[7:0];
         if (fill_push) begin
            addr <= addr + VRAM_AW'(1);
            cnt <= cnt - DATA_WIDTH'(1);
         end else if (!busy && wr_addr) addr <= bus_wdata[VRAM_AW-1:0];
         else if (cpu_push) addr <= addr + VRAM_AW'(1);
         if (!busy && wr_fcnt) cnt <= bus_wdata;
         vram_we <= pop;
         if (pop) {vram_addr, vram_wdata} <= dout;
      end
endmodule

// File: tb/tb_mcpu_vram_bridge.sv
// tb_mcpu_vram_bridge: directed self-checking bench for mcpu_vram_bridge
module tb_mcpu_vram_bridge;
   localparam logic [15:0] BASE = 16'hFF00;
   logic clk = 1'b0, reset = 1'b1;
   logic [15:0] bus_addr = '0, bus_wdata = '0, bus_rdata;
   logic bus_we = 1'b0, bus_re = 1'b0, bus_rdata_oe, display_on = 1'b0;
   logic [12:0] vram_addr;
   logic [7:0] vram_wdata;
   logic vram_we;
   logic [20:0] cap[$];
   logic [15:0] rv;
   int vectors = 0, miscompares = 0;

   mcpu_vram_bridge dut (
      .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
      .bus_re(bus_re), .bus_rdata(bus_rdata), .bus_rdata_oe(bus_rdata_oe), .display_on(display_on),
      .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (vram_we) cap.push_back({vram_addr, vram_wdata});

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] v);
      bus_addr = a;
      bus_wdata = v;
      bus_we = 1'b1;
      @(posedge clk);
      #1 bus_we = 1'b0;
   endtask

   task automatic peek(input logic [15:0] a, output logic [15:0] v);
      bus_addr = a;
      bus_re = 1'b1;
      #1 v = bus_rdata;
      bus_re = 1'b0;
   endtask

   task automatic read_clr(input logic [15:0] a);
      bus_addr = a;
      bus_re = 1'b1;
      @(posedge clk);
      #1 bus_re = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      cycles(2);
      reset = 1'b0;
      chk("rst_vram_we", vram_we, 0);
      chk("rst_vram_addr", vram_addr, 0);
      peek(BASE + 1, rv);
      chk("rst_status", rv, 16'h0001);
      peek(BASE, rv);
      chk("rst_addr", rv, 0);

      // Two CPU writes in blanking: 2-clock latency to vram_we.
      wr(BASE, 16'h0100);
      wr(BASE + 1, 16'h0041);
      chk("lat_we_early", vram_we, 0);
      wr(BASE + 1, 16'h0042);
      chk("lat_we1", vram_we, 1);
      chk("lat_w1", {vram_addr, vram_wdata}, {13'h0100, 8'h41});
      cycles(1);
      chk("lat_we2", vram_we, 1);
      chk("lat_w2", {vram_addr, vram_wdata}, {13'h0101, 8'h42});
      cycles(1);
      chk("lat_we_off", vram_we, 0);
      peek(BASE, rv);
      chk("addr_after", rv, 16'h0102);

      // Fill FIFO during active display, overflow on 17th push.
      display_on = 1'b1;
      for (int i = 0; i < 16; i++) wr(BASE + 1, 16'(16'h50 + i));
      peek(BASE + 1, rv);
      chk("full_status", rv, 16'h1012);
      wr(BASE + 1, 16'h0099);
      peek(BASE + 1, rv);
      chk("ovf_status", rv, 16'h101A);
      read_clr(BASE + 1);
      peek(BASE + 1, rv);
      chk("ovf_cleared", rv, 16'h1012);
      peek(BASE, rv);
      chk("addr_no_inc_drop", rv, 16'h0112);
      cap.delete();
      display_on = 1'b0;
      cycles(20);
      chk("drain_count", cap.size(), 16);
      for (int i = 0; i < 16; i++) chk("drain_entry", cap[i], {13'(13'h102 + i), 8'(8'h50 + i)});
      peek(BASE + 1, rv);
      chk("drained_status", rv, 16'h0001);

      // Fill across the VRAM address wrap, with a conflicting DATA write.
      wr(BASE + 2, 16'h0020);
      wr(BASE, 16'h1FFE);
      cap.delete();
      wr(BASE + 3, 16'd4);
      peek(BASE + 1, rv);
      chk("fill_busy_start", rv[2], 1);
      cycles(1);
      wr(BASE + 1, 16'h0077);
      peek(BASE + 1, rv);
      chk("fill_busy_mid", rv[2], 1);
      cycles(1);
      peek(BASE + 1, rv);
      chk("fill_busy_3rd", rv[2], 1);
      cycles(1);
      peek(BASE + 1, rv);
      chk("fill_busy_done", rv[2], 0);
      chk("fill_ovf", rv[3], 1);
      cycles(6);
      peek(BASE + 1, rv);
      chk("fill_end_status", rv, 16'h0009);
      read_clr(BASE + 1);
      chk("fill_count", cap.size(), 4);
      chk("fill_w0", cap[0], {13'h1FFE, 8'h20});
      chk("fill_w1", cap[1], {13'h1FFF, 8'h20});
      chk("fill_w2", cap[2], {13'h0000, 8'h20});
      chk("fill_w3", cap[3], {13'h0001, 8'h20});
      peek(BASE, rv);
      chk("fill_addr_end", rv, 16'h0002);
      peek(BASE + 3, rv);
      chk("fill_cnt_end", rv, 0);

      // Long fill stalls on a full FIFO, then completes in blanking.
      display_on = 1'b1;
      wr(BASE + 2, 16'h0033);
      wr(BASE, 16'h0200);
      wr(BASE + 3, 16'd40);
      cycles(20);
      peek(BASE + 1, rv);
      chk("stall_status", rv, 16'h1016);
      peek(BASE + 3, rv);
      chk("stall_remaining", rv, 16'd24);
      cap.delete();
      display_on = 1'b0;
      cycles(60);
      chk("long_count", cap.size(), 40);
      for (int i = 0; i < 40; i++) chk("long_entry", cap[i], {13'(13'h200 + i), 8'h33});
      peek(BASE + 1, rv);
      chk("long_status", rv, 16'h0001);

      // Reset mid-fill with 10 entries queued.
      display_on = 1'b1;
      wr(BASE, 16'h0300);
      wr(BASE + 3, 16'd40);
      cycles(10);
      peek(BASE + 1, rv);
      chk("pre_reset_status", rv, 16'h0A14);
      cap.delete();
      display_on = 1'b0;
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      chk("reset_we", vram_we, 0);
      peek(BASE + 1, rv);
      chk("reset_status", rv, 16'h0001);
      peek(BASE, rv);
      chk("reset_addr", rv, 0);
      peek(BASE + 3, rv);
      chk("reset_cnt", rv, 0);
      cycles(10);
      chk("reset_no_writes", cap.size(), 0);

      // Addresses just outside the window.
      bus_addr = BASE - 1;
      bus_re = 1'b1;
      #1 chk("oe_below", bus_rdata_oe, 0);
      bus_addr = BASE + 4;
      #1 chk("oe_above", bus_rdata_oe, 0);
      bus_addr = BASE;
      #1 chk("oe_hit", bus_rdata_oe, 1);
      bus_re = 1'b0;
      wr(BASE - 1, 16'h1234);
      wr(BASE + 4, 16'h0055);
      wr(BASE + 5, 16'h0007);
      cycles(4);
      peek(BASE, rv);
      chk("miss_addr", rv, 0);
      peek(BASE + 2, rv);
      chk("miss_fval", rv, 0);
      peek(BASE + 3, rv);
      chk("miss_cnt", rv, 0);
      peek(BASE + 1, rv);
      chk("miss_status", rv, 16'h0001);
      chk("miss_no_writes", cap.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
